// File: rtl/ring_scheduler_if.sv
// Request/grant bundle between the requesters and the ring scheduler.
// The master drives requests; the scheduler (slave) returns grant and status.
interface ring_scheduler_if #(
    parameter int N = 8
);
    logic [N-1:0]         req;
    logic [N-1:0]         grant;
    logic [$clog2(N)-1:0] owner;
    logic [N-1:0]         ptr;
    logic                 busy;
    logic                 timeout;

    modport master (
        output req,
        input  grant, owner, ptr, busy, timeout
    );

    modport slave (
        input  req,
        output grant, owner, ptr, busy, timeout
    );
endinterface

// File: rtl/ring_scheduler.sv
// Round-robin arbiter over N requesters with a bounded tenure and a one-cycle
// gap between grants. The ring pointer only advances when someone wins.
module ring_scheduler #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          init,
    ring_scheduler_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    grant_reg, grant_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [N-1:0]    ptr_reg, ptr_next;
    logic [HW-1:0]   hold_reg, hold_next;
    logic            busy_reg, busy_next;
    logic            timeout_reg, timeout_next;

    logic [N-1:0]    at_or_above;
    logic [N-1:0]    masked_req;
    logic [N-1:0]    pick;
    logic [N-1:0]    win_oh;
    logic [N-1:0]    win_rot;
    logic [IW-1:0]   win_idx;

    // Requests at or above the pointer get first pick; otherwise wrap to bit 0.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_thermo
            assign at_or_above[gi] = |ptr_reg[gi:0];
        end
    endgenerate

    assign masked_req = bus.req & at_or_above;
    assign pick       = (|masked_req) ? masked_req : bus.req;
    assign win_oh     = pick & (~pick + N'(1));
    assign win_rot    = {win_oh[N-2:0], win_oh[N-1]};

    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    state_next   = GRANT;
                    grant_next   = win_oh;
                    owner_next   = win_idx;
                    hold_next    = '0;
                    ptr_next     = win_rot;
                    timeout_next = 1'b0;
                end
            end
            GRANT: begin
                hold_next = hold_reg + HW'(1);
                // A voluntary release takes precedence over the hold limit.
                if (!bus.req[owner_reg]) begin
                    state_next   = GAP;
                    grant_next   = '0;
                    owner_next   = '0;
                    timeout_next = 1'b0;
                end else if (hold_reg == HW'(MAX_HOLD - 1)) begin
                    state_next   = GAP;
                    grant_next   = '0;
                    owner_next   = '0;
                    timeout_next = 1'b1;
                end
            end
            GAP: begin
                state_next   = IDLE;
                timeout_next = 1'b0;
            end
            default: begin
                state_next   = IDLE;
                grant_next   = '0;
                owner_next   = '0;
                timeout_next = 1'b0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            owner_reg   <= '0;
            ptr_reg     <= N'(1);
            hold_reg    <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.grant   = grant_reg;
    assign bus.owner   = owner_reg;
    assign bus.ptr     = ptr_reg;
    assign bus.busy    = busy_reg;
    assign bus.timeout = timeout_reg;
endmodule

// File: tb/tb_ring_scheduler.sv
// Bench for ring_scheduler: tenure-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ring_scheduler;
    localparam int N        = 8;
    localparam int MAX_HOLD = 16;

    logic clk  = 1'b0;
    logic init = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ring_scheduler_if #(.N(N)) bus ();

    ring_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = no tenure, 1 = tenure running, 2 = gap cycle.
    int m_phase = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_used  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or posedge init) begin
        if (init) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_used = 0; m_to = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    int w;
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                    if (w >= 0) begin
                        m_phase = 1; m_owner = w; m_ptr = (w + 1) % N;
                        m_used = 0; m_to = 1'b0;
                    end
                end
                1: begin
                    m_used++;
                    if (!bus.req[m_owner]) begin
                        m_phase = 2; m_to = 1'b0;
                    end else if (m_used == MAX_HOLD) begin
                        m_phase = 2; m_to = 1'b1;
                    end
                end
                default: begin
                    m_phase = 0; m_to = 1'b0;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] eg, eo;
        eg = (m_phase == 1) ? (32'd1 << m_owner) : 32'd0;
        eo = (m_phase == 1) ? 32'(m_owner) : 32'd0;
        chk("model grant", 32'(bus.grant), eg);
        chk("model owner", 32'(bus.owner), eo);
        chk("model ptr", 32'(bus.ptr), 32'd1 << m_ptr);
        chk("model busy", 32'(bus.busy), 32'(m_phase != 0));
        chk("model timeout", 32'(bus.timeout), 32'(m_to && m_phase == 2));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) $display("grant owner=%0d grant=%h ptr=%h", bus.owner, bus.grant, bus.ptr);
        else chk("wait_grant bound", 32'd0, 32'd1);
    endtask

    task automatic go_idle();
        bit ok;
        ok = 1'b0;
        bus.req = '0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("go_idle bound", 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        int n;
        int own;
        bus.req = '0;
        #1 init = 1'b1;
        repeat (2) tick();
        chk("reset grant", 32'(bus.grant), 32'h0);
        chk("reset owner", 32'(bus.owner), 32'h0);
        chk("reset ptr", 32'(bus.ptr), 32'h01);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset timeout", 32'(bus.timeout), 32'h0);
        init = 1'b0;

        // Full rotation with 3-cycle tenures.
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_grant(ok);
            own = int'(bus.owner);
            chk("rotation owner", 32'(own), 32'(i % 8));
            if (i == 7) chk("rotation ptr after 7", 32'(bus.ptr), 32'h01);
            repeat (2) tick();
            chk("rotation hold", 32'(bus.grant), 32'd1 << (i % 8));
            bus.req = 8'hFF & ~(8'd1 << own);
            tick();
            chk("rotation gap grant", 32'(bus.grant), 32'h0);
            chk("rotation gap busy", 32'(bus.busy), 32'h1);
            bus.req = 8'hFF;
            tick();
            chk("rotation idle busy", 32'(bus.busy), 32'h0);
        end
        go_idle();

        // Wraparound: ptr at 4 after owner 3, then 0 and 3 request.
        bus.req = 8'h08;
        wait_grant(ok);
        chk("wrap setup ptr", 32'(bus.ptr), 32'h10);
        go_idle();
        bus.req = 8'h09;
        wait_grant(ok);
        chk("wrap grant", 32'(bus.grant), 32'h01);
        chk("wrap owner", 32'(bus.owner), 32'h0);
        chk("wrap ptr", 32'(bus.ptr), 32'h02);
        go_idle();

        // Hold limit with a continuously requesting owner.
        bus.req = 8'h20;
        wait_grant(ok);
        n = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.grant == 8'h20) n++;
            else break;
        end
        chk("limit tenure length", 32'(n), 32'd16);
        chk("limit timeout pulse", 32'(bus.timeout), 32'h1);
        chk("limit gap busy", 32'(bus.busy), 32'h1);
        tick();
        chk("limit timeout cleared", 32'(bus.timeout), 32'h0);
        chk("limit idle busy", 32'(bus.busy), 32'h0);
        tick();
        chk("limit regrant", 32'(bus.grant), 32'h20);
        go_idle();

        // Release on the same edge as the hold limit.
        bus.req = 8'h04;
        wait_grant(ok);
        repeat (15) tick();
        chk("tie last grant cycle", 32'(bus.grant), 32'h04);
        bus.req = '0;
        tick();
        chk("tie gap grant", 32'(bus.grant), 32'h0);
        chk("tie gap timeout", 32'(bus.timeout), 32'h0);
        chk("tie gap busy", 32'(bus.busy), 32'h1);
        go_idle();

        // Asynchronous init during a tenure of owner 6.
        bus.req = 8'h40;
        wait_grant(ok);
        chk("abort owner", 32'(bus.owner), 32'h6);
        tick();
        #2 init = 1'b1;
        #1;
        chk("abort grant", 32'(bus.grant), 32'h0);
        chk("abort ptr", 32'(bus.ptr), 32'h01);
        bus.req = 8'h41;
        #1 init = 1'b0;
        tick();
        chk("restart grant", 32'(bus.grant), 32'h01);
        chk("restart owner", 32'(bus.owner), 32'h0);
        go_idle();

        // Randomized traffic segments, occasionally with an init pulse.
        for (int seg = 0; seg < 150; seg++) begin
            int len, kind;
            logic [N-1:0] v;
            len  = $urandom_range(1, 40);
            kind = $urandom_range(0, 4);
            v    = N'($urandom);
            if (kind == 2) v = N'(1) << $urandom_range(0, N - 1);
            for (int c = 0; c < len; c++) begin
                tick();
                case (kind)
                    1:       bus.req = N'($urandom);
                    3:       bus.req = ($urandom_range(0, 3) == 0) ? N'($urandom) : bus.req;
                    default: bus.req = v;
                endcase
                if (kind == 4 && c == len / 2) begin
                    #2 init = 1'b1;
                    #1;
                    chk("random init grant", 32'(bus.grant), 32'h0);
                    chk("random init ptr", 32'(bus.ptr), 32'h01);
                    #1 init = 1'b0;
                end
            end
            $display("segment %0d kind=%0d len=%0d req=%h", seg, kind, len, bus.req);
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
